// File: rtl/spi_master_ctrl_pkg.sv
// spi_master_ctrl_pkg: command codes and FSM state encoding shared by the SPI master files.
package spi_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        SEND,
        RD_WAIT_ST,
        RECV,
        GAP
    } state_e;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: command handshake, read return and serial lines of the SPI master.
interface spi_master_ctrl_if #(parameter int ADDR_SIZE = 8);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_type;
    logic [ADDR_SIZE-1:0] cmd_data;
    logic                 busy;
    logic                 rd_valid;
    logic [ADDR_SIZE-1:0] rd_data;
    logic                 SS_n;
    logic                 MOSI;
    logic                 MISO;

    modport master (
        input  cmd_valid, cmd_type, cmd_data, MISO,
        output cmd_ready, busy, rd_valid, rd_data, SS_n, MOSI
    );

    modport slave (
        output cmd_valid, cmd_type, cmd_data, MISO,
        input  cmd_ready, busy, rd_valid, rd_data, SS_n, MOSI
    );
endinterface

// File: rtl/spi_master_ctrl_shifter.sv
// spi_master_shifter: loadable PISO driving a registered MOSI, MISO SIPO, shared bit counter.
module spi_master_shifter #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [ADDR_SIZE+2:0] word_i,
    input  logic                 shift_i,
    input  logic                 recv_i,
    input  logic                 miso_i,
    output logic                 mosi_o,
    output logic [ADDR_SIZE-1:0] rx_o,
    output logic                 done_o
);
    localparam int FW = ADDR_SIZE + 3;
    localparam int CW = $clog2(FW + 1);

    logic [FW-1:0]        tx_q, tx_d;
    logic [ADDR_SIZE-2:0] rx_q, rx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 mosi_q, mosi_d;

    // The counter runs only while shifting, so it restarts at zero for each phase.
    always_comb begin
        tx_d   = load_i ? word_i : shift_i ? {tx_q[FW-2:0], 1'b0} : tx_q;
        mosi_d = shift_i & tx_q[FW-1];
        rx_d   = recv_i ? rx_o[ADDR_SIZE-2:0] : rx_q;
        cnt_d  = (shift_i | recv_i) ? cnt_q + CW'(1) : '0;
    end

    assign rx_o   = {rx_q, miso_i};
    assign mosi_o = mosi_q;
    assign done_o = cnt_q == (recv_i ? CW'(ADDR_SIZE - 1) : CW'(FW));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q   <= '0;
            rx_q   <= '0;
            cnt_q  <= '0;
            mosi_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            cnt_q  <= cnt_d;
            mosi_q <= mosi_d;
        end
    end
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: serialises one RAM command per handshake onto SS_n/MOSI, one bit per clk,
// and captures the byte returned on MISO for read-data commands.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int ADDR_SIZE  = 8,
    parameter int RD_WAIT    = 3,
    parameter int GAP_CYCLES = 1
) (
    input logic               clk,
    input logic               rst_n,
    spi_master_ctrl_if.master bus_if
);
    localparam int CW = $clog2(RD_WAIT + GAP_CYCLES + 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    cmd_e                 type_q;
    logic                 ss_n_q, rd_valid_q;
    logic [ADDR_SIZE-1:0] rd_data_q, rx;
    logic                 load, done, rx_done, last_wait, last_gap;

    assign load      = state_q == IDLE && bus_if.cmd_valid;
    assign rx_done   = state_q == RECV && done;
    assign last_wait = cnt_q == CW'(RD_WAIT - 1);
    assign last_gap  = cnt_q == CW'(GAP_CYCLES - 1);

    spi_master_shifter #(.ADDR_SIZE(ADDR_SIZE)) u_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .word_i ({bus_if.cmd_type[1], bus_if.cmd_type, bus_if.cmd_data}),
        .shift_i(state_d == SEND),
        .recv_i (state_q == RECV),
        .miso_i (bus_if.MISO),
        .mosi_o (bus_if.MOSI),
        .rx_o   (rx),
        .done_o (done)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE:       state_d = load ? SEL : IDLE;
            SEL:        state_d = SEND;
            SEND:       state_d = !done ? SEND : type_q == CMD_RD_DATA ? RD_WAIT_ST : GAP;
            RD_WAIT_ST: begin
                cnt_d   = last_wait ? '0 : cnt_q + CW'(1);
                state_d = last_wait ? RECV : RD_WAIT_ST;
            end
            RECV:       state_d = done ? GAP : RECV;
            GAP:        begin
                cnt_d   = last_gap ? '0 : cnt_q + CW'(1);
                state_d = last_gap ? IDLE : GAP;
            end
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            type_q     <= CMD_WR_ADDR;
            ss_n_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ss_n_q     <= state_d == IDLE || state_d == GAP;
            rd_valid_q <= rx_done;
            if (load) type_q <= cmd_e'(bus_if.cmd_type);
            if (rx_done) rd_data_q <= rx;
        end
    end

    assign bus_if.cmd_ready = state_q == IDLE;
    assign bus_if.busy      = state_q != IDLE;
    assign bus_if.SS_n      = ss_n_q;
    assign bus_if.rd_valid  = rd_valid_q;
    assign bus_if.rd_data   = rd_data_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed bench with a cycle-level model of the SPI slave + RAM wrapper.
module tb_spi_master_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    spi_master_ctrl_if #(.ADDR_SIZE(8)) bus ();

    spi_master_ctrl #(.ADDR_SIZE(8), .RD_WAIT(3), .GAP_CYCLES(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_if(bus)
    );

    always #5 clk = ~clk;

    // Slave model: frame bits arrive in SS_n-low cycles 2..12, read byte returned MSB first
    // in cycles 16..23 (after RD_WAIT=3 idle cycles).
    logic [7:0]  mem [256];
    logic [7:0]  wa, ra, rbyte;
    logic [10:0] frame;
    int          cnt, last_len, cyc, hi_run, min_gap, accepts;
    int          fall_cyc, rdv_cyc, rdv_pulses;
    logic        prev_ss, ss_at_rdv;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
        wa = 0; ra = 0; rbyte = 0; frame = 0;
        cnt = 0; last_len = 0; cyc = 0; hi_run = 0; min_gap = 1000; accepts = 0;
        fall_cyc = 0; rdv_cyc = 0; rdv_pulses = 0; prev_ss = 1; ss_at_rdv = 0;
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.cmd_valid && bus.cmd_ready && rst_n) accepts = accepts + 1;
        if (!rst_n) begin
            cnt = 0;
        end else if (!bus.SS_n) begin
            if (hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
            hi_run = 0;
            cnt = cnt + 1;
            if (cnt >= 2 && cnt <= 12) frame = {frame[9:0], bus.MOSI};
            if (cnt == 12) begin
                case (frame[9:8])
                    2'b00: wa = frame[7:0];
                    2'b01: mem[wa] = frame[7:0];
                    2'b10: ra = frame[7:0];
                    default: rbyte = mem[ra];
                endcase
            end
        end else begin
            if (cnt != 0) last_len = cnt;
            cnt = 0;
            hi_run = hi_run + 1;
        end
    end

    always @(negedge clk) begin
        bus.MISO = (!bus.SS_n && cnt >= 15 && cnt <= 22) ? rbyte[22-cnt] : 1'b0;
        if (prev_ss && !bus.SS_n) fall_cyc = cyc;
        if (bus.rd_valid) begin
            rdv_pulses = rdv_pulses + 1;
            rdv_cyc = cyc;
            ss_at_rdv = bus.SS_n;
        end
        prev_ss = bus.SS_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] t, input logic [7:0] d);
        int n = 0;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 32'(n < 100), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = t;
        bus.cmd_data  = d;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 200), 1);
    endtask

    initial begin
        int pulses;
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = 2'b00;
        bus.cmd_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ss_n", bus.SS_n, 1);
        chk("rst_mosi", bus.MOSI, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_ready", bus.cmd_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'b00, 8'h02);
        @(negedge clk);
        chk("acc_ready_low", bus.cmd_ready, 0);
        chk("acc_busy", bus.busy, 1);
        chk("acc_ss_low", bus.SS_n, 0);
        chk("acc_sel_mosi", bus.MOSI, 0);
        wait_idle();
        chk("wa2_frame", frame, 11'h002);
        chk("wa2_len", last_len, 12);
        chk("idle_busy", bus.busy, 0);

        issue(2'b01, 8'h08);
        wait_idle();
        chk("wd8_frame", frame, 11'h108);
        chk("mem2", mem[2], 8'h08);

        issue(2'b00, 8'h64);
        repeat (6) @(negedge clk);
        chk("mid_ready_low", bus.cmd_ready, 0);
        wait_idle();
        issue(2'b01, 8'h0E);
        repeat (11) @(negedge clk);
        chk("mid_ready_low2", bus.cmd_ready, 0);
        wait_idle();
        chk("mem100", mem[100], 8'h0E);

        issue(2'b10, 8'h02);
        wait_idle();
        chk("ra_frame", frame, 11'h602);
        chk("ra_len", last_len, 12);
        pulses = rdv_pulses;
        issue(2'b11, 8'h00);
        wait_idle();
        chk("rd_frame", frame, 11'h700);
        chk("rd_len", last_len, 23);
        chk("rd_pulses", rdv_pulses - pulses, 1);
        chk("rd_latency", rdv_cyc - fall_cyc, 23);
        chk("rd_ss_high", ss_at_rdv, 1);
        chk("rd_data8", bus.rd_data, 8'h08);

        issue(2'b10, 8'h64);
        wait_idle();
        issue(2'b11, 8'h00);
        wait_idle();
        chk("rd_data14", bus.rd_data, 8'h0E);

        issue(2'b10, 8'h07);
        wait_idle();
        issue(2'b11, 8'h3C);
        wait_idle();
        chk("rd_frame_dc", frame, 11'h73C);
        chk("rd_data_7", bus.rd_data, 8'h07 ^ 8'h5A);

        issue(2'b00, 8'h33);
        wait_idle();
        chk("rd_data_hold", bus.rd_data, 8'h07 ^ 8'h5A);

        min_gap = 1000;
        accepts = 0;
        bus.cmd_type  = 2'b00;
        bus.cmd_data  = 8'h05;
        bus.cmd_valid = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        wait_idle();
        chk("b2b_accepts", accepts, 3);
        chk("b2b_min_gap", min_gap, 2);

        pulses = rdv_pulses;
        issue(2'b11, 8'h00);
        repeat (4) @(negedge clk);
        chk("pre_rst_ss_low", bus.SS_n, 0);
        rst_n = 1'b0;
        #1;
        chk("mrst_ss_n", bus.SS_n, 1);
        chk("mrst_mosi", bus.MOSI, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_rd_valid", bus.rd_valid, 0);
        chk("mrst_rd_data", bus.rd_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("mrst_no_rdv", rdv_pulses - pulses, 0);
        chk("mrst_idle", bus.cmd_ready, 1);
        issue(2'b10, 8'hA5);
        wait_idle();
        chk("post_rst_frame", frame, 11'h6A5);
        chk("post_rst_len", last_len, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
